// File: rtl/trap_ctl.sv
// trap_ctl -- machine-mode trap controller.
//
// Owns the trap CSRs (MSTATUS.MIE/MPIE, MIE, MIP, MTVEC, MEPC, MCAUSE, MTVAL).
// It synchronises NUM_IRQ external interrupt lines, each of which is either
// level- or edge-triggered. The highest-index pending line has priority. The
// block dispatches synchronous exceptions and interrupts to MTVEC and handles
// MRET.
//
// Optional feature macro: TRAP_CTL_VECTORED_EN
//   defined   : MTVEC[1:0] is writable. 0 selects direct mode, 1 selects
//               vectored mode, and writes of 2 or 3 leave the mode unchanged.
//   undefined : MTVEC[1:0] reads 0 and every trap goes to the base address.
//
// Ports
//   clk, rst              core clock, asynchronous active-high reset
//   irq[NUM_IRQ]          asynchronous interrupt lines (line i -> cause 16+i)
//   inst_boundary, pc     instruction retires this cycle / its PC
//   exc_valid/cause/tval  synchronous exception request
//   mret                  MRET retiring this cycle
//   csr_we/addr/wdata     CSR write port
//   csr_rdata, csr_hit    combinational CSR read data / address owned
//   trap_taken            PC redirect strobe (one cycle)
//   trap_pc               redirect target (trap vector or MEPC)
//   trap_is_irq           the redirect is an interrupt entry
module trap_ctl #(
    parameter int unsigned        XLEN        = 32,
    parameter int unsigned        NUM_IRQ     = 8,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK   = '0,
    parameter int unsigned        SYNC_STAGES = 2,
    parameter logic [XLEN-1:0]    RESET_TVEC  = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               inst_boundary,
    input  logic [XLEN-1:0]    pc,
    input  logic               exc_valid,
    input  logic [4:0]         exc_cause,
    input  logic [XLEN-1:0]    exc_tval,
    input  logic               mret,
    input  logic               csr_we,
    input  logic [11:0]        csr_addr,
    input  logic [XLEN-1:0]    csr_wdata,
    output logic [XLEN-1:0]    csr_rdata,
    output logic               csr_hit,
    output logic               trap_taken,
    output logic [XLEN-1:0]    trap_pc,
    output logic               trap_is_irq
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] irq_level, irq_rise;
    logic [NUM_IRQ-1:0] edge_pend_q;
    logic [NUM_IRQ-1:0] mie_q;
    logic [NUM_IRQ-1:0] mip, pending;
    logic [3:0]         irq_idx;
    logic [4:0]         irq_cause;
    logic               irq_any;

    logic               mstatus_mie_q, mstatus_mpie_q;
    logic [XLEN-3:0]    mtvec_base_q;
    logic [XLEN-1:0]    mepc_q, mcause_q, mtval_q;
    logic [XLEN-1:0]    trap_pc_q;
    logic               trap_is_irq_q;

    logic [XLEN-1:0]    mepc_rd, tvec_base, tvec_rd, entry_pc;
    logic               take_exc, take_irq, take_mret, trap_entry;
    logic               wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause;
    logic               wr_mtval, wr_mip;

    // ---- irq synchronisers -------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= irq;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign irq_level = sync_q[SYNC_STAGES-1];
    // The rise is detected one stage early so that edge lines reach MIP with
    // the same SYNC_STAGES latency as level lines.
    assign irq_rise  = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];

    // ---- pending / priority ------------------------------------------------
    assign mip     = (EDGE_MASK & edge_pend_q) | (~EDGE_MASK & irq_level);
    assign pending = mip & mie_q;

    always_comb begin
        irq_idx = '0;
        irq_any = 1'b0;
        // The last hit wins, so the highest index has priority.
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (pending[i]) begin
                irq_idx = 4'(i);
                irq_any = 1'b1;
            end
        end
    end

    assign irq_cause = 5'd16 + 5'(irq_idx);

    // ---- request arbitration: exception > interrupt > mret -----------------
    always_comb begin
        take_exc  = 1'b0;
        take_irq  = 1'b0;
        take_mret = 1'b0;
        if (state_q == ST_RUN) begin
            if (exc_valid)
                take_exc = 1'b1;
            else if (inst_boundary && mstatus_mie_q && irq_any)
                take_irq = 1'b1;
            else if (mret)
                take_mret = 1'b1;
        end
    end

    assign trap_entry = take_exc | take_irq;

    // ---- FSM ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (trap_entry || take_mret) state_d = ST_TRAP;
            ST_TRAP: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    assign trap_taken = (state_q == ST_TRAP);

    // ---- CSR write decode --------------------------------------------------
    // A software write loses to the hardware update of the same CSR.
    assign wr_mstatus = csr_we && (csr_addr == CSR_MSTATUS) && !trap_entry && !take_mret;
    assign wr_mie     = csr_we && (csr_addr == CSR_MIE);
    assign wr_mtvec   = csr_we && (csr_addr == CSR_MTVEC);
    assign wr_mepc    = csr_we && (csr_addr == CSR_MEPC)   && !trap_entry;
    assign wr_mcause  = csr_we && (csr_addr == CSR_MCAUSE) && !trap_entry;
    assign wr_mtval   = csr_we && (csr_addr == CSR_MTVAL)  && !trap_entry;
    assign wr_mip     = csr_we && (csr_addr == CSR_MIP);

    // ---- edge-pending bits -------------------------------------------------
    // A new edge sets the bit even when a clearing write lands in the same
    // cycle. A written 1 never sets the bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            edge_pend_q <= '0;
        else
            edge_pend_q <= EDGE_MASK &
                           (irq_rise | (edge_pend_q &
                            ~(wr_mip ? ~csr_wdata[16 +: NUM_IRQ] : '0)));
    end

    // ---- trap target -------------------------------------------------------
    assign tvec_base = {mtvec_base_q, 2'b00};
    assign mepc_rd   = mepc_q & ~XLEN'(3);

`ifdef TRAP_CTL_VECTORED_EN
    logic mtvec_mode_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mtvec_mode_q <= (RESET_TVEC[1:0] == 2'b01);
        else if (wr_mtvec && !csr_wdata[1])
            mtvec_mode_q <= csr_wdata[0];
    end

    assign tvec_rd  = {mtvec_base_q, 1'b0, mtvec_mode_q};
    assign entry_pc = (mtvec_mode_q && take_irq) ?
                      tvec_base + XLEN'({irq_cause, 2'b00}) : tvec_base;
`else
    assign tvec_rd  = tvec_base;
    assign entry_pc = tvec_base;
`endif

    // ---- CSR state ---------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_base_q   <= RESET_TVEC[XLEN-1:2];
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            trap_pc_q      <= '0;
            trap_is_irq_q  <= 1'b0;
        end else begin
            if (trap_entry) begin
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
            end else if (take_mret) begin
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
            end else if (wr_mstatus) begin
                mstatus_mie_q  <= csr_wdata[3];
                mstatus_mpie_q <= csr_wdata[7];
            end

            if (wr_mie)   mie_q        <= csr_wdata[16 +: NUM_IRQ];
            if (wr_mtvec) mtvec_base_q <= csr_wdata[XLEN-1:2];

            if (take_exc) begin
                mepc_q   <= pc;
                mcause_q <= XLEN'(exc_cause);
                mtval_q  <= exc_tval;
            end else if (take_irq) begin
                mepc_q   <= pc;
                mcause_q <= {1'b1, (XLEN-1)'(irq_cause)};
                mtval_q  <= '0;
            end else begin
                if (wr_mepc)   mepc_q   <= csr_wdata;
                if (wr_mcause) mcause_q <= csr_wdata;
                if (wr_mtval)  mtval_q  <= csr_wdata;
            end

            if (trap_entry) begin
                trap_pc_q     <= entry_pc;
                trap_is_irq_q <= take_irq;
            end else if (take_mret) begin
                trap_pc_q     <= mepc_rd;
                trap_is_irq_q <= 1'b0;
            end
        end
    end

    assign trap_pc     = trap_pc_q;
    assign trap_is_irq = trap_is_irq_q;

    // ---- CSR read ----------------------------------------------------------
    always_comb begin
        csr_rdata = '0;
        csr_hit   = 1'b1;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rdata[3]     = mstatus_mie_q;
                csr_rdata[7]     = mstatus_mpie_q;
                csr_rdata[12:11] = 2'b11;
            end
            CSR_MIE:    csr_rdata = XLEN'({mie_q, 16'h0000});
            CSR_MTVEC:  csr_rdata = tvec_rd;
            CSR_MEPC:   csr_rdata = mepc_rd;
            CSR_MCAUSE: csr_rdata = mcause_q;
            CSR_MTVAL:  csr_rdata = mtval_q;
            CSR_MIP:    csr_rdata = XLEN'({mip, 16'h0000});
            default:    csr_hit   = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_trap_ctl.sv
module tb_trap_ctl;

    localparam int XLEN = 32;
    localparam int NIRQ = 8;

`ifdef TRAP_CTL_VECTORED_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;
    localparam logic [11:0] A_MIP     = 12'h344;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NIRQ-1:0] irq = '0;
    logic            inst_boundary = 1'b0;
    logic [XLEN-1:0] pc = '0;
    logic            exc_valid = 1'b0;
    logic [4:0]      exc_cause = '0;
    logic [XLEN-1:0] exc_tval = '0;
    logic            mret = 1'b0;
    logic            csr_we = 1'b0;
    logic [11:0]     csr_addr = '0;
    logic [XLEN-1:0] csr_wdata = '0;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_hit;
    logic            trap_taken;
    logic [XLEN-1:0] trap_pc;
    logic            trap_is_irq;

    typedef struct packed {
        logic [31:0] tpc;
        logic        is_irq;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    trap_ctl #(
        .XLEN(XLEN), .NUM_IRQ(NIRQ), .EDGE_MASK(8'h01),
        .SYNC_STAGES(2), .RESET_TVEC(32'h100)
    ) dut (
        .clk(clk), .rst(rst), .irq(irq), .inst_boundary(inst_boundary),
        .pc(pc), .exc_valid(exc_valid), .exc_cause(exc_cause),
        .exc_tval(exc_tval), .mret(mret), .csr_we(csr_we),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .csr_hit(csr_hit), .trap_taken(trap_taken), .trap_pc(trap_pc),
        .trap_is_irq(trap_is_irq)
    );

    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_we    = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
        tick();
        csr_we    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] e);
        csr_addr = a;
        #1;
        chk(tag, csr_rdata, e);
    endtask

    task automatic push(input logic [31:0] tpc, input logic is_irq);
        exp_t e;
        e.tpc    = tpc;
        e.is_irq = is_irq;
        sb.push_back(e);
    endtask

    // Scoreboard consumer: every redirect must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && trap_taken) begin
            if (sb.size() == 0) begin
                chk("trap_unexpected", {31'b0, trap_taken}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("trap_pc", trap_pc, e.tpc);
                chk("trap_is_irq", {31'b0, trap_is_irq}, {31'b0, e.is_irq});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_taken", {31'b0, trap_taken}, 32'h0);
        chk("rst_tpc", trap_pc, 32'h0);
        chk("rst_tirq", {31'b0, trap_is_irq}, 32'h0);
        rd("rst_mstatus", A_MSTATUS, 32'h1800);
        rd("rst_mtvec", A_MTVEC, 32'h100);
        rd("rst_mepc", A_MEPC, 32'h0);
        rd("rst_mcause", A_MCAUSE, 32'h0);
        rd("rst_mtval", A_MTVAL, 32'h0);
        rd("rst_mip", A_MIP, 32'h0);
        rd("rst_mie", A_MIE, 32'h0);
        chk("hit_own", {31'b0, csr_hit}, 32'h1);
        csr_addr = 12'h123;
        #1;
        chk("hit_unowned", {31'b0, csr_hit}, 32'h0);
        chk("rd_unowned", csr_rdata, 32'h0);

        // Exception with a colliding MTVAL write (dropped)
        pc = 32'h40; exc_cause = 5'd2; exc_tval = 32'hDEAD; exc_valid = 1'b1;
        csr_we = 1'b1; csr_addr = A_MTVAL; csr_wdata = 32'h1234;
        push(32'h100, 1'b0);
        tick();
        exc_valid = 1'b0; csr_we = 1'b0;
        chk("exc_taken", {31'b0, trap_taken}, 32'h1);
        rd("exc_mcause", A_MCAUSE, 32'h2);
        rd("exc_mepc", A_MEPC, 32'h40);
        rd("exc_mtval", A_MTVAL, 32'hDEAD);
        rd("exc_mstatus", A_MSTATUS, 32'h1800);
        tick();
        chk("exc_one_cycle", {31'b0, trap_taken}, 32'h0);

        // Level interrupt on line 2, vectored dispatch
        csr_wr(A_MSTATUS, 32'h8);
        csr_wr(A_MIE, 32'h40000);
        csr_wr(A_MTVEC, 32'h101);
        rd("mtvec_w1", A_MTVEC, VEC ? 32'h101 : 32'h100);
        csr_wr(A_MTVEC, 32'h102);
        rd("mtvec_w2", A_MTVEC, VEC ? 32'h101 : 32'h100);
        rd("mie_rd", A_MIE, 32'h40000);
        irq = 8'h04;
        tick();
        rd("mip_lat1", A_MIP, 32'h0);
        tick();
        rd("mip_lat2", A_MIP, 32'h40000);
        pc = 32'h80; inst_boundary = 1'b1;
        push(VEC ? 32'h148 : 32'h100, 1'b1);
        tick();
        inst_boundary = 1'b0;
        chk("irq_taken", {31'b0, trap_taken}, 32'h1);
        rd("irq_mcause", A_MCAUSE, 32'h80000012);
        rd("irq_mepc", A_MEPC, 32'h80);
        rd("irq_mtval", A_MTVAL, 32'h0);
        rd("irq_mstatus", A_MSTATUS, 32'h1880);
        tick();
        irq = 8'h00;
        repeat (3) tick();

        // Level pulse gone before the boundary is not taken
        csr_wr(A_MSTATUS, 32'h8);
        irq = 8'h04;
        tick();
        irq = 8'h00;
        tick();
        tick();
        rd("lvl_gone_mip", A_MIP, 32'h0);
        pc = 32'h90; inst_boundary = 1'b1;
        tick();
        inst_boundary = 1'b0;
        chk("lvl_gone_taken", {31'b0, trap_taken}, 32'h0);

        // Edge line 0
        irq = 8'h01;
        tick();
        irq = 8'h00;
        tick();
        tick();
        rd("edge_hold", A_MIP, 32'h10000);
        csr_wr(A_MIP, 32'h0);
        rd("edge_clr", A_MIP, 32'h0);
        csr_wr(A_MIP, 32'h10000);
        rd("edge_w1", A_MIP, 32'h0);
        irq = 8'h01;
        tick();
        irq = 8'h00;
        csr_we = 1'b1; csr_addr = A_MIP; csr_wdata = 32'h0;
        tick();
        csr_we = 1'b0;
        rd("edge_vs_clr", A_MIP, 32'h10000);
        csr_wr(A_MIP, 32'h0);
        rd("edge_clr2", A_MIP, 32'h0);

        // Exception beats pending interrupts; mret; then irq 5 wins
        csr_wr(A_MIE, 32'h220000);
        irq = 8'h22;
        tick();
        tick();
        rd("two_mip", A_MIP, 32'h220000);
        pc = 32'h300; exc_cause = 5'd5; exc_tval = 32'h77;
        exc_valid = 1'b1; inst_boundary = 1'b1;
        push(32'h100, 1'b0);
        tick();
        exc_valid = 1'b0; inst_boundary = 1'b0;
        rd("prio_mcause", A_MCAUSE, 32'h5);
        rd("prio_mstatus", A_MSTATUS, 32'h1880);
        tick();
        mret = 1'b1;
        push(32'h300, 1'b0);
        tick();
        mret = 1'b0;
        rd("mret1_mstatus", A_MSTATUS, 32'h1888);
        tick();
        pc = 32'h304; inst_boundary = 1'b1;
        push(VEC ? 32'h154 : 32'h100, 1'b1);
        tick();
        inst_boundary = 1'b0;
        rd("irq5_mcause", A_MCAUSE, 32'h80000015);
        rd("irq5_mepc", A_MEPC, 32'h304);
        tick();
        irq = 8'h00;
        repeat (3) tick();

        // mret to MEPC=0x200, plus a CSR write during the TRAP cycle
        csr_wr(A_MSTATUS, 32'h80);
        csr_wr(A_MEPC, 32'h202);
        rd("mepc_mask", A_MEPC, 32'h200);
        mret = 1'b1;
        push(32'h200, 1'b0);
        tick();
        mret = 1'b0;
        rd("mret2_mstatus", A_MSTATUS, 32'h1888);
        csr_wr(A_MTVAL, 32'h55);
        rd("trap_cycle_wr", A_MTVAL, 32'h55);
        tick();

        // Asynchronous reset during the TRAP cycle
        pc = 32'h500; exc_cause = 5'd7; exc_valid = 1'b1;
        tick();
        exc_valid = 1'b0;
        chk("pre_rst_taken", {31'b0, trap_taken}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("arst_taken", {31'b0, trap_taken}, 32'h0);
        chk("arst_tpc", trap_pc, 32'h0);
        chk("arst_tirq", {31'b0, trap_is_irq}, 32'h0);
        rd("arst_mcause", A_MCAUSE, 32'h0);
        rd("arst_mepc", A_MEPC, 32'h0);
        rd("arst_mtval", A_MTVAL, 32'h0);
        rd("arst_mstatus", A_MSTATUS, 32'h1800);
        rd("arst_mtvec", A_MTVEC, 32'h100);
        rd("arst_mie", A_MIE, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("sb_left", sb.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trap_ctl.md
# trap_ctl

Parametrised machine-mode trap controller, successor to the single-cycle exception encoder in the core. It owns the trap CSRs (MSTATUS.MIE/MPIE, MIE, MIP, MTVEC, MEPC, MCAUSE, MTVAL). It adds N synchronised external interrupt lines with per-line level/edge mode, fixed priority, vectored dispatch and MRET handling. It sits beside the core control unit, between the exception detectors and the PC mux.

## Interface
- XLEN, 32, data/address width.
- NUM_IRQ, 8, external interrupt lines (1..16); line i reports cause 16+i.
- EDGE_MASK, 0, NUM_IRQ-bit; bit i=1 makes line i edge-triggered, 0 level-triggered.
- SYNC_STAGES, 2, synchroniser flops per irq line (>=2).
- RESET_TVEC, 0, MTVEC reset value.
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- irq  in  NUM_IRQ  asynchronous external interrupt lines.
- inst_boundary  in  1  pulse: current instruction retires this cycle (write_pc).
- pc  in  XLEN  PC of the instruction at the boundary/faulting instruction.
- exc_valid  in  1  synchronous exception this cycle.
- exc_cause  in  5  exception code (mcause low bits).
- exc_tval  in  XLEN  value for MTVAL.
- mret  in  1  MRET retiring this cycle.
- csr_we  in  1  CSR write strobe.
- csr_addr  in  12  CSR address.
- csr_wdata  in  XLEN  CSR write data.
- csr_rdata  out  XLEN  combinational read data; 0 for unowned addresses.
- csr_hit  out  1  csr_addr is owned by this block.
- trap_taken  out  1  registered; redirect PC to trap_pc this cycle.
- trap_pc  out  XLEN  trap target or MEPC on return.
- trap_is_irq  out  1  the trap being taken is an interrupt.

## Operation
- Owned CSRs: MSTATUS 0x300 (MIE bit 3, MPIE bit 7, MPP bits 12:11 read 2'b11, others 0), MIE 0x304, MTVEC 0x305, MEPC 0x341 (bits 1:0 read 0), MCAUSE 0x342, MTVAL 0x343, MIP 0x344. MIE/MIP implement bits 16+i only.
- Each irq line passes through SYNC_STAGES flops.
  - Level lines: MIP bit = synchronised level, read-only.
  - Edge lines: MIP bit set on synchronised rising edge; cleared only by a CSR write of 0 to that bit. Writes of 1 are ignored.
- pending = MIP & MIE. An interrupt is eligible when MSTATUS.MIE=1 and pending!=0. The highest-index pending line wins.
- FSM RUN -> TRAP -> RUN. TRAP lasts exactly one cycle with trap_taken=1.
- In RUN, requests are taken in priority order:
  1. exc_valid: MEPC<=pc, MCAUSE<={0,exc_cause}, MTVAL<=exc_tval.
  2. inst_boundary with an eligible interrupt: MEPC<=pc, MCAUSE<={1,cause}, MTVAL<=0.
  3. mret: trap_pc<=MEPC, MIE<=MPIE, MPIE<=1.
- On trap entry (1 and 2): MPIE<=MIE, MIE<=0. trap_pc is MTVEC base (bits 1:0 cleared); in vectored mode with an interrupt it is base+4*cause.
- Inputs arriving while in TRAP are ignored; the core does not issue them.
- A CSR write in the same cycle as trap entry is dropped for every CSR updated by the trap. A CSR write in the TRAP cycle applies normally.

## Timing
- Reset values: state RUN, trap_taken=0, trap_pc=0, trap_is_irq=0, MIE/MPIE=0, MIE reg=0, MIP=0, MEPC=0, MCAUSE=0, MTVAL=0, MTVEC=RESET_TVEC, synchronisers 0.
- Interrupt latency: SYNC_STAGES cycles from irq rise to MIP, then the next inst_boundary, then trap_taken one cycle later.
- Exception and mret: trap_taken in the cycle after the request. CSRs are updated at the same edge.
- Simultaneous events:
  - Edge set beats a CSR clear in the same cycle.
  - Exception beats interrupt beats mret.
  - An irq deasserting before inst_boundary on a level line is not taken.
- Asynchronous reset mid-trap returns to RUN with all reset values immediately.

## Configuration
- TRAP_CTL_VECTORED_EN defined: MTVEC[1:0] is writable with values 0 (direct) or 1 (vectored); writes of 2 or 3 leave mode unchanged.
- TRAP_CTL_VECTORED_EN undefined: MTVEC[1:0] is hardwired to 0 and all traps go to the base.

## Test plan
- Reset with RESET_TVEC=0x100, then exc_valid with cause 2, pc=0x40, tval=0xDEAD -> one cycle later trap_taken=1, trap_pc=0x100, MCAUSE=0x2, MEPC=0x40, MTVAL=0xDEAD, MSTATUS.MIE=0.
- MSTATUS.MIE=1, MIE bit 18 set, level irq[2] high -> after 2 cycles MIP=0x40000; next inst_boundary gives MCAUSE=0x80000012. Vectored MTVEC=0x101 -> trap_pc=0x148.
- Edge line irq[0]: pulse one cycle -> MIP bit 16 stays set. A CSR write of 0 clears it. A write coinciding with a new edge leaves it set.
- irq[1] and irq[5] pending simultaneously with exc_valid -> exception taken first (MCAUSE=exc code). After mret -> MIE restored, then irq[5] taken (cause 0x80000015).
- mret with MEPC=0x200, MPIE=1 -> trap_pc=0x200, MSTATUS.MIE=1, MPIE=1, trap_is_irq=0.
- Assert rst during the TRAP cycle -> trap_taken drops immediately and all CSRs read reset values.
